// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes and the execute-unit state encoding.
// ALU_* codes are the same constants the ALU control decoder drives onto alu_ctrl.
package cpu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic {
        IDLE,
        MUL
    } alu_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier datapath (low DATA_W bits of the product).
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (clears acc and cnt)
//   load_i           capture mcand_i/mplier_i, clear acc and cnt
//   step_i           perform one shift-add iteration
//   mcand_i/mplier_i operands captured on load_i
//   done_o           the current step is the last one (cnt == DATA_W-1)
//   product_o        accumulator value after the current step (valid as result when done_o)
module mul_iter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] mcand_i,
    input  logic [DATA_W-1:0] mplier_i,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign done_o    = (cnt_q == CNT_W'(DATA_W - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, multi-cycle MUL via mul_iter.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i / ready_o     operation handshake; ready_o high iff state is IDLE
//   alu_ctrl_i            operation code (cpu_pkg ALU_*), unknown codes yield 0
//   data1_i, data2_i      operands A and B
//   flush_i               cancels in-flight or offered operation; outputs held
//   valid_o               one-cycle pulse when result_o/zero_o update
//   result_o, zero_o      last completed result and its zero flag (registered)
module ex_alu_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        alu_ctrl_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    alu_state_e        state_q;
    logic [DATA_W-1:0] op_result;
    logic              accept;
    logic              mul_load;
    logic              mul_step;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    assign ready_o  = (state_q == IDLE);
    assign accept   = ready_o & valid_i & ~flush_i;
    assign mul_load = accept & (alu_ctrl_i == ALU_MUL);
    assign mul_step = (state_q == MUL) & ~flush_i;

    always_comb begin
        op_result = '0;
        case (alu_ctrl_i)
            ALU_AND: op_result = data1_i & data2_i;
            ALU_OR:  op_result = data1_i | data2_i;
            ALU_ADD: op_result = data1_i + data2_i;
            ALU_SUB: op_result = data1_i - data2_i;
            default: op_result = '0;
        endcase
    end

    mul_iter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_mul_iter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (mul_load),
        .step_i    (mul_step),
        .mcand_i   (data1_i),
        .mplier_i  (data2_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Priority: reset > flush > acceptance > iteration.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b1;
        end else if (flush_i) begin
            state_q <= IDLE;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        if (alu_ctrl_i == ALU_MUL) begin
                            state_q <= MUL;
                        end else begin
                            result_o <= op_result;
                            zero_o   <= (op_result == '0);
                            valid_o  <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        result_o <= mul_product;
                        zero_o   <= (mul_product == '0);
                        valid_o  <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed self-checking bench for ex_alu_unit (DATA_W = 32).
module tb_ex_alu_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  alu_ctrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        flush_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic        zero_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ex_alu_unit #(
        .DATA_W (32)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .alu_ctrl_i (alu_ctrl_i),
        .data1_i    (data1_i),
        .data2_i    (data2_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .zero_o     (zero_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Single-cycle op: offer, accept at next edge, check pulse, then pulse ends.
    task automatic do_op(input string tag, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        valid_i    = 1'b1;
        alu_ctrl_i = c;
        data1_i    = a;
        data2_i    = b;
        tick();
        valid_i = 1'b0;
        check({tag, " valid"}, 32'(valid_o), 32'd1);
        check({tag, " result"}, result_o, exp);
        check({tag, " zero"}, 32'(zero_o), 32'(exp == 32'd0));
        tick();
        check({tag, " pulse end"}, 32'(valid_o), 32'd0);
    endtask

    // Wait out a MUL already accepted at the previous edge; bounded at 100 cycles.
    task automatic wait_mul(input string tag, input logic [31:0] exp);
        int low_cnt = 0;
        int early   = 0;
        while (ready_o === 1'b0 && low_cnt < 100) begin
            if (valid_o !== 1'b0) early++;
            low_cnt++;
            tick();
        end
        check({tag, " ready low cycles"}, 32'(low_cnt), 32'd32);
        check({tag, " no early valid"}, 32'(early), 32'd0);
        check({tag, " valid"}, 32'(valid_o), 32'd1);
        check({tag, " result"}, result_o, exp);
        check({tag, " zero"}, 32'(zero_o), 32'(exp == 32'd0));
    endtask

    task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
        valid_i    = 1'b1;
        alu_ctrl_i = 3'b111;
        data1_i    = a;
        data2_i    = b;
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
        int vcount;
        rst_i      = 1'b1;
        valid_i    = 1'b0;
        flush_i    = 1'b0;
        alu_ctrl_i = 3'b000;
        data1_i    = '0;
        data2_i    = '0;
        tick();
        tick();
        check("reset ready", 32'(ready_o), 32'd1);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset zero", 32'(zero_o), 32'd1);
        rst_i = 1'b0;
        tick();

        // Single-cycle ops
        do_op("add 7+5", 3'b010, 32'd7, 32'd5, 32'd12);
        do_op("sub 5-5", 3'b110, 32'd5, 32'd5, 32'd0);
        do_op("sub 0-1", 3'b110, 32'd0, 32'd1, 32'hFFFF_FFFF);
        do_op("and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        do_op("or", 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        do_op("code 011", 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);

        // Multiplies
        start_mul(32'd12345, 32'd6789);
        wait_mul("mul 12345x6789", 32'd83810205);
        tick();
        check("mul pulse end", 32'(valid_o), 32'd0);
        start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_mul("mul ffff^2", 32'd1);
        tick();
        start_mul(32'd0, 32'hDEAD_BEEF);
        wait_mul("mul 0xX", 32'd0);
        tick();

        // MUL then ADD held on valid_i through the busy period
        start_mul(32'd6, 32'd7);
        valid_i    = 1'b1;
        alu_ctrl_i = 3'b010;
        data1_i    = 32'd100;
        data2_i    = 32'd1;
        wait_mul("b2b mul", 32'd42);
        tick();
        valid_i = 1'b0;
        check("b2b add valid", 32'(valid_o), 32'd1);
        check("b2b add result", result_o, 32'd101);
        tick();
        check("b2b add pulse end", 32'(valid_o), 32'd0);

        // Flush at iteration 10
        start_mul(32'd12345, 32'd6789);
        repeat (9) tick();
        check("flush pre ready", 32'(ready_o), 32'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush ready", 32'(ready_o), 32'd1);
        check("flush valid", 32'(valid_o), 32'd0);
        check("flush result kept", result_o, 32'd101);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o !== 1'b0) vcount++;
            tick();
        end
        check("flush no late pulse", 32'(vcount), 32'd0);
        check("flush result still", result_o, 32'd101);

        // Flush together with an offered ADD drops it
        valid_i    = 1'b1;
        flush_i    = 1'b1;
        alu_ctrl_i = 3'b010;
        data1_i    = 32'd3;
        data2_i    = 32'd4;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("flush+add valid", 32'(valid_o), 32'd0);
        check("flush+add result", result_o, 32'd101);
        tick();
        check("flush+add later valid", 32'(valid_o), 32'd0);

        // Reset mid-MUL
        start_mul(32'd12345, 32'd6789);
        repeat (5) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid rst ready", 32'(ready_o), 32'd1);
        check("mid rst valid", 32'(valid_o), 32'd0);
        check("mid rst result", result_o, 32'd0);
        check("mid rst zero", 32'(zero_o), 32'd1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o !== 1'b0) vcount++;
            tick();
        end
        check("mid rst no pulse", 32'(vcount), 32'd0);
        do_op("add 1+1", 3'b010, 32'd1, 32'd1, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
